smi_request_type_demux: RTL and testbench

// - Routes SMI request frames from one upstream port to a read or write request port, by frame type byte (header flit data[7:0]).
// - Sits directly upstream of the SMI-to-AXI read and write adaptors. They rely on this block to filter frame types.
// - Frames with an unrecognised type byte are drained and discarded.

---
 rtl/smi_request_type_demux.sv | 150 +++++++++++++++
 tb/tb_smi_request_type_demux.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_request_type_demux.sv
// SMI request demux: routes frames to the read or write port by header type byte, drops others.
// Optional discarded-frame counter on dropCount when SMI_DEMUX_DROP_COUNT_EN is defined.
module smi_request_type_demux #(
    parameter int           DataIndexSize = 4,
    parameter logic [7:0]   ReadReqId     = 8'h02,
    parameter logic [7:0]   WriteReqId    = 8'h01,
    localparam int          DataWidth     = (1 << DataIndexSize) * 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 smiInReady,
    input  logic [7:0]           smiInEofc,
    input  logic [DataWidth-1:0] smiInData,
    output logic                 smiInStop,
    output logic                 smiRdReady,
    output logic [7:0]           smiRdEofc,
    output logic [DataWidth-1:0] smiRdData,
    input  logic                 smiRdStop,
    output logic                 smiWrReady,
    output logic [7:0]           smiWrEofc,
    output logic [DataWidth-1:0] smiWrData,
    input  logic                 smiWrStop
`ifdef SMI_DEMUX_DROP_COUNT_EN
    ,
    output logic [15:0]          dropCount
`endif
);

    typedef enum logic [1:0] {IDLE, ROUTE_RD, ROUTE_WR, DISCARD} state_t;

    state_t                 state_q, state_d;

    logic                   inValid_q;
    logic [7:0]             inEofc_q;
    logic [DataWidth-1:0]   inData_q;

    logic                   rdValid_q;
    logic [7:0]             rdEofc_q;
    logic [DataWidth-1:0]   rdData_q;

    logic                   wrValid_q;
    logic [7:0]             wrEofc_q;
    logic [DataWidth-1:0]   wrData_q;

    logic                   selRd, selWr, inHalt, inMove, rdLoad, wrLoad, dropHdr;

    always_ff @(posedge clk) begin
        if (srst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Selection is decoded from the header still sitting in the input register,
    // so the routing decision and the header's forward move happen in the same cycle.
    always_comb begin
        selRd   = 1'b0;
        selWr   = 1'b0;
        dropHdr = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (inData_q[7:0] == ReadReqId)       selRd   = 1'b1;
                else if (inData_q[7:0] == WriteReqId) selWr   = 1'b1;
                else                                  dropHdr = inValid_q;
            end
            ROUTE_RD: selRd = 1'b1;
            ROUTE_WR: selWr = 1'b1;
            default:  ;
        endcase

        inHalt = (selRd & rdValid_q & smiRdStop) | (selWr & wrValid_q & smiWrStop);
        inMove = inValid_q & ~inHalt;
        rdLoad = inMove & selRd;
        wrLoad = inMove & selWr;

        if (inMove) begin
            case (state_q)
                IDLE: begin
                    if (inEofc_q == 8'd0) begin
                        if (selRd)      state_d = ROUTE_RD;
                        else if (selWr) state_d = ROUTE_WR;
                        else            state_d = DISCARD;
                    end
                end
                default: if (inEofc_q != 8'd0) state_d = IDLE;
            endcase
        end
    end

    assign smiInStop = inValid_q & inHalt;

    always_ff @(posedge clk) begin
        if (srst) begin
            inValid_q <= 1'b0;
            inEofc_q  <= '0;
            inData_q  <= '0;
            rdValid_q <= 1'b0;
            rdEofc_q  <= '0;
            rdData_q  <= '0;
            wrValid_q <= 1'b0;
            wrEofc_q  <= '0;
            wrData_q  <= '0;
        end else begin
            if (!smiInStop) begin
                inValid_q <= smiInReady;
                if (smiInReady) begin
                    inEofc_q <= smiInEofc;
                    inData_q <= smiInData;
                end
            end

            if (rdLoad) begin
                rdValid_q <= 1'b1;
                rdEofc_q  <= inEofc_q;
                rdData_q  <= inData_q;
            end else if (rdValid_q && !smiRdStop) begin
                rdValid_q <= 1'b0;
            end

            if (wrLoad) begin
                wrValid_q <= 1'b1;
                wrEofc_q  <= inEofc_q;
                wrData_q  <= inData_q;
            end else if (wrValid_q && !smiWrStop) begin
                wrValid_q <= 1'b0;
            end
        end
    end

    assign smiRdReady = rdValid_q;
    assign smiRdEofc  = rdEofc_q;
    assign smiRdData  = rdData_q;
    assign smiWrReady = wrValid_q;
    assign smiWrEofc  = wrEofc_q;
    assign smiWrData  = wrData_q;

`ifdef SMI_DEMUX_DROP_COUNT_EN
    logic [15:0] dropCount_q;

    always_ff @(posedge clk) begin
        if (srst)                                   dropCount_q <= '0;
        else if (dropHdr && dropCount_q != 16'hFFFF) dropCount_q <= dropCount_q + 16'd1;
    end

    assign dropCount = dropCount_q;
`else
    logic unusedDrop;
    assign unusedDrop = dropHdr;
`endif

endmodule

// File: tb/tb_smi_request_type_demux.sv
// Bench for smi_request_type_demux: cycle-exact vector table, reset sequence, and a
// randomized frame run checked against a frame-level expectation queue per port.
module tb_smi_request_type_demux;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          srst;
    logic          smiInReady;
    logic [7:0]    smiInEofc;
    logic [DW-1:0] smiInData;
    logic          smiInStop;
    logic          smiRdReady, smiWrReady;
    logic [7:0]    smiRdEofc, smiWrEofc;
    logic [DW-1:0] smiRdData, smiWrData;
    logic          smiRdStop, smiWrStop;
`ifdef SMI_DEMUX_DROP_COUNT_EN
    logic [15:0]   dropCount;
`endif

    smi_request_type_demux dut (
        .clk(clk), .srst(srst),
        .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
        .smiRdReady(smiRdReady), .smiRdEofc(smiRdEofc), .smiRdData(smiRdData), .smiRdStop(smiRdStop),
        .smiWrReady(smiWrReady), .smiWrEofc(smiWrEofc), .smiWrData(smiWrData), .smiWrStop(smiWrStop)
`ifdef SMI_DEMUX_DROP_COUNT_EN
        , .dropCount(dropCount)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        ir;  logic [7:0] ie; logic [15:0] id; logic rs; logic ws;
        logic        eis; logic err; logic [7:0] ere; logic [15:0] erd;
        logic        ewr; logic [7:0] ewe; logic [15:0] ewd;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [7:0]    e;
    } flit_t;

    vec_t  tbl[$];
    flit_t src_q[$], rd_exp[$], wr_exp[$];
    flit_t rd_prev, wr_prev;
    logic  rd_hold, wr_hold, mon_en, in_xfer;
    int    exp_drop;

    function automatic vec_t V(input logic ir, input logic [7:0] ie, input logic [15:0] id,
                               input logic rs, input logic ws, input logic eis,
                               input logic err, input logic [7:0] ere, input logic [15:0] erd,
                               input logic ewr, input logic [7:0] ewe, input logic [15:0] ewd);
        vec_t v;
        v.ir = ir; v.ie = ie; v.id = id; v.rs = rs; v.ws = ws; v.eis = eis;
        v.err = err; v.ere = ere; v.erd = erd; v.ewr = ewr; v.ewe = ewe; v.ewd = ewd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        flit_t f;
        if (rd_hold) begin
            chk("rd_hold_ready", DW'(smiRdReady), DW'(1'b1));
            chk("rd_hold_data", smiRdData, rd_prev.d);
            chk("rd_hold_eofc", DW'(smiRdEofc), DW'(rd_prev.e));
        end
        if (smiRdReady && !smiRdStop) begin
            if (rd_exp.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL rd_extra: got flit %0h expected none", smiRdData);
            end else begin
                f = rd_exp.pop_front();
                chk("rd_data", smiRdData, f.d);
                chk("rd_eofc", DW'(smiRdEofc), DW'(f.e));
            end
        end
        if (wr_hold) begin
            chk("wr_hold_ready", DW'(smiWrReady), DW'(1'b1));
            chk("wr_hold_data", smiWrData, wr_prev.d);
            chk("wr_hold_eofc", DW'(smiWrEofc), DW'(wr_prev.e));
        end
        if (smiWrReady && !smiWrStop) begin
            if (wr_exp.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL wr_extra: got flit %0h expected none", smiWrData);
            end else begin
                f = wr_exp.pop_front();
                chk("wr_data", smiWrData, f.d);
                chk("wr_eofc", DW'(smiWrEofc), DW'(f.e));
            end
        end
        rd_hold = smiRdReady && smiRdStop; rd_prev.d = smiRdData; rd_prev.e = smiRdEofc;
        wr_hold = smiWrReady && smiWrStop; wr_prev.d = smiWrData; wr_prev.e = smiWrEofc;
    endtask

    task automatic step();
        @(negedge clk);
        if (mon_en) monitor();
        in_xfer = smiInReady && !smiInStop;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        smiInReady = 1'b0; smiInEofc = '0; smiInData = '0;
        smiRdStop = 1'b0; smiWrStop = 1'b0;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        smiInReady = v.ir; smiInEofc = v.ie; smiInData = DW'(v.id);
        smiRdStop = v.rs; smiWrStop = v.ws;
        @(negedge clk);
        chk({tag, "_inStop"}, DW'(smiInStop), DW'(v.eis));
        chk({tag, "_rdReady"}, DW'(smiRdReady), DW'(v.err));
        chk({tag, "_wrReady"}, DW'(smiWrReady), DW'(v.ewr));
        if (v.err) begin
            chk({tag, "_rdEofc"}, DW'(smiRdEofc), DW'(v.ere));
            chk({tag, "_rdData"}, smiRdData, DW'(v.erd));
        end
        if (v.ewr) begin
            chk({tag, "_wrEofc"}, DW'(smiWrEofc), DW'(v.ewe));
            chk({tag, "_wrData"}, smiWrData, DW'(v.ewd));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        flit_t f;
        int    len, r, cyc;
        logic [7:0] typ;

        mon_en = 1'b0; in_xfer = 1'b0; rd_hold = 1'b0; wr_hold = 1'b0; exp_drop = 0;

        //        ir ie     id      rs ws  is rr ere    erd      wr ewe    ewd
        tbl.push_back(V(1, 8'h00, 16'h1102, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h00, 16'h1200, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h10, 16'h1300, 0, 0, 0, 1, 8'h00, 16'h1102, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h08, 16'h2101, 0, 0, 0, 1, 8'h00, 16'h1200, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h08, 16'h3102, 0, 0, 0, 1, 8'h10, 16'h1300, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 8'h08, 16'h2101));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 1, 8'h08, 16'h3102, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h00, 16'h4102, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h00, 16'h4200, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        for (int i = 0; i < 5; i++)
            tbl.push_back(V(1, 8'h00, 16'h4300, 1, 0, 1, 1, 8'h00, 16'h4102, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h00, 16'h4300, 0, 0, 0, 1, 8'h00, 16'h4102, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h10, 16'h4400, 0, 0, 0, 1, 8'h00, 16'h4200, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 1, 8'h00, 16'h4300, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 1, 8'h10, 16'h4400, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        // 4-flit bad-type frame, then a 2-flit read frame
        tbl.push_back(V(1, 8'h00, 16'h507E, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h00, 16'h5200, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h00, 16'h5300, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h04, 16'h5400, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h00, 16'h6102, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h20, 16'h6200, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 1, 8'h00, 16'h6102, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 1, 8'h20, 16'h6200, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        // stalled read port must not block a following write frame
        tbl.push_back(V(1, 8'h01, 16'h7102, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(1, 8'h01, 16'h7201, 1, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 1, 0, 0, 1, 8'h01, 16'h7102, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 1, 0, 0, 1, 8'h01, 16'h7102, 1, 8'h01, 16'h7201));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 1, 8'h01, 16'h7102, 0, 8'h00, 16'h0000));
        tbl.push_back(V(0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000));

        do_reset();
        @(negedge clk);
        chk("rst_inStop", DW'(smiInStop), DW'(1'b0));
        chk("rst_rdReady", DW'(smiRdReady), DW'(1'b0));
        chk("rst_wrReady", DW'(smiWrReady), DW'(1'b0));
        chk("rst_rdEofc", DW'(smiRdEofc), DW'(8'h00));
        chk("rst_wrEofc", DW'(smiWrEofc), DW'(8'h00));
        chk("rst_rdData", smiRdData, '0);
        chk("rst_wrData", smiWrData, '0);
`ifdef SMI_DEMUX_DROP_COUNT_EN
        chk("rst_dropCount", DW'(dropCount), DW'(16'h0000));
`endif
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));
`ifdef SMI_DEMUX_DROP_COUNT_EN
        @(negedge clk);
        chk("table_dropCount", DW'(dropCount), DW'(16'h0001));
        @(posedge clk); #1;
`endif

        // reset while the second flit of a 4-flit read frame is in flight
        apply(V(1, 8'h00, 16'h8102, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000), "mrst_a");
        apply(V(1, 8'h00, 16'h8200, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000), "mrst_b");
        srst = 1'b1;
        apply(V(0, 8'h00, 16'h0000, 0, 0, 0, 1, 8'h00, 16'h8102, 0, 8'h00, 16'h0000), "mrst_c");
        srst = 1'b0;
        apply(V(1, 8'h01, 16'h9101, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000), "mrst_d");
        apply(V(0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000), "mrst_e");
        apply(V(0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 8'h01, 16'h9101), "mrst_f");
        apply(V(0, 8'h00, 16'h0000, 0, 0, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000), "mrst_g");

        // randomized frames: expectations are whole frames queued to their destination port
        do_reset();
        for (int fr = 0; fr < 60; fr++) begin
            len = $urandom_range(1, 5);
            r   = $urandom_range(0, 9);
            if (r < 4)      typ = 8'h02;
            else if (r < 8) typ = 8'h01;
            else begin
                typ = 8'($urandom);
                while (typ == 8'h01 || typ == 8'h02) typ = 8'($urandom);
                exp_drop++;
            end
            for (int k = 0; k < len; k++) begin
                f.d = {$urandom, $urandom, $urandom, $urandom};
                if (k == 0) f.d[7:0] = typ;
                f.e = (k == len - 1) ? 8'($urandom_range(1, 255)) : 8'h00;
                src_q.push_back(f);
                if (typ == 8'h02)      rd_exp.push_back(f);
                else if (typ == 8'h01) wr_exp.push_back(f);
            end
        end
        mon_en = 1'b1; in_xfer = 1'b0; rd_hold = 1'b0; wr_hold = 1'b0;
        cyc = 0;
        while ((src_q.size() > 0 || rd_exp.size() > 0 || wr_exp.size() > 0) && cyc < 6000) begin
            if (!(smiInReady && !in_xfer)) begin
                if (src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    smiInReady = 1'b1; smiInData = src_q[0].d; smiInEofc = src_q[0].e;
                end else begin
                    smiInReady = 1'b0; smiInData = '0; smiInEofc = '0;
                end
            end
            smiRdStop = ($urandom_range(0, 2) == 0);
            smiWrStop = ($urandom_range(0, 2) == 0);
            step();
            if (in_xfer) f = src_q.pop_front();
            cyc++;
        end
        chk("random_drain_left", DW'(src_q.size() + rd_exp.size() + wr_exp.size()), '0);
        smiInReady = 1'b0; smiRdStop = 1'b0; smiWrStop = 1'b0;
        repeat (4) step();
        mon_en = 1'b0;
`ifdef SMI_DEMUX_DROP_COUNT_EN
        @(negedge clk);
        chk("random_dropCount", DW'(dropCount), DW'(16'(exp_drop)));
        @(posedge clk); #1;

        do_reset();
        smiInReady = 1'b1; smiInEofc = 8'h01; smiInData = DW'(8'h7E);
        repeat (65537) @(posedge clk);
        #1 smiInReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sat_dropCount", DW'(dropCount), DW'(16'hFFFF));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
